// File: rtl/key_press_classifier.sv
// Classifies debounced active-low key actions into short, long and double
// pulses using one shared duration counter and a registered pressed level.
module key_press_classifier #(
  parameter int CNT_W    = 8,
  parameter int LONG_CYC = 16,
  parameter int DBL_GAP  = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic short_p,
  output logic long_p,
  output logic double_p,
  output logic pressed
);

  localparam logic [2:0] ARM    = 3'd0;
  localparam logic [2:0] IDLE   = 3'd1;
  localparam logic [2:0] PRESS1 = 3'd2;
  localparam logic [2:0] WAIT2  = 3'd3;
  localparam logic [2:0] PRESS2 = 3'd4;
  localparam logic [2:0] HOLD   = 3'd5;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP - 1);

  logic [2:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             short_n, long_n, double_n, pressed_n;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    short_n  = 1'b0;
    long_n   = 1'b0;
    double_n = 1'b0;
    unique case (state)
      ARM: begin
        if (key_in) state_n = IDLE;
      end
      IDLE: begin
        if (!key_in) begin
          state_n = PRESS1;
          cnt_n   = ONE;
        end
      end
      PRESS1: begin
        if (key_in) begin
          state_n = WAIT2;
          cnt_n   = ONE;
        end else if (cnt == LONG_LAST) begin
          state_n = HOLD;
          long_n  = 1'b1;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      WAIT2: begin
        // A low sample wins over a timeout landing on the same sample
        if (!key_in) begin
          state_n = PRESS2;
          cnt_n   = ONE;
        end else if (cnt == GAP_LAST) begin
          state_n = IDLE;
          short_n = 1'b1;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      PRESS2: begin
        if (key_in) begin
          state_n  = IDLE;
          double_n = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_n  = HOLD;
          double_n = 1'b1;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      HOLD: begin
        if (key_in) state_n = IDLE;
      end
      default: state_n = ARM;
    endcase
  end

  assign pressed_n = (state_n == PRESS1) ||
                     (state_n == PRESS2) ||
                     (state_n == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARM;
      cnt      <= '0;
      short_p  <= 1'b0;
      long_p   <= 1'b0;
      double_p <= 1'b0;
      pressed  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      short_p  <= short_n;
      long_p   <= long_n;
      double_p <= double_n;
      pressed  <= pressed_n;
    end
  end

endmodule

// File: tb/tb_key_press_classifier.sv
// Bench for key_press_classifier: directed action scenarios plus random
// key run lengths against a run-length reference model.
module tb_key_press_classifier;

  localparam int CNT_W    = 8;
  localparam int LONG_CYC = 16;
  localparam int DBL_GAP  = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic key_in;
  logic short_p, long_p, double_p, pressed;

  key_press_classifier #(
    .CNT_W   (CNT_W),
    .LONG_CYC(LONG_CYC),
    .DBL_GAP (DBL_GAP)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key_in  (key_in),
    .short_p (short_p),
    .long_p  (long_p),
    .double_p(double_p),
    .pressed (pressed)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_s, n_l, n_d;

  bit armed, hold, down;
  int presses, run_len;
  bit e_s, e_l, e_d, e_p;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    armed   = 0;
    hold    = 0;
    down    = 0;
    presses = 0;
    run_len = 0;
    e_s = 0; e_l = 0; e_d = 0; e_p = 0;
  endtask

  // Action-level model: number of presses in the action and current run length
  task automatic model(input bit k);
    e_s = 0; e_l = 0; e_d = 0;
    if (!armed) begin
      armed = k;
    end else if (hold) begin
      if (k) hold = 0;
    end else if (!k) begin
      if (!down) begin
        presses++;
        down    = 1;
        run_len = 1;
      end else begin
        run_len++;
      end
      if (run_len == LONG_CYC) begin
        if (presses == 1) e_l = 1;
        else e_d = 1;
        hold    = 1;
        down    = 0;
        presses = 0;
      end
    end else begin
      if (down) begin
        down = 0;
        if (presses == 2) begin
          e_d     = 1;
          presses = 0;
        end else begin
          run_len = 1;
        end
      end else if (presses == 1) begin
        run_len++;
      end
      if (presses == 1 && run_len == DBL_GAP) begin
        e_s     = 1;
        presses = 0;
      end
    end
    e_p = down || hold;
  endtask

  task automatic step(input bit k);
    key_in = k;
    @(posedge clk);
    model(k);
    #1;
    n_s += int'(short_p);
    n_l += int'(long_p);
    n_d += int'(double_p);
    chk("out", {28'd0, short_p, long_p, double_p, pressed},
        {28'd0, e_s, e_l, e_d, e_p});
  endtask

  task automatic run(input bit k, input int n);
    repeat (n) step(k);
  endtask

  task automatic clr();
    n_s = 0; n_l = 0; n_d = 0;
  endtask

  task automatic cnt_chk(input string tag, input int s, input int l,
                         input int d);
    chk({tag, "_short"}, n_s, s);
    chk({tag, "_long"}, n_l, l);
    chk({tag, "_double"}, n_d, d);
  endtask

  task automatic do_reset(input bit k);
    key_in = k;
    rst_n  = 1'b0;
    #1;
    model_reset();
    chk("rst_async", {28'd0, short_p, long_p, double_p, pressed}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_hold", {28'd0, short_p, long_p, double_p, pressed}, 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    bit lvl;
    rst_n  = 1'b0;
    key_in = 1'b1;
    model_reset();
    clr();
    #2;
    do_reset(1'b1);
    run(1, 2);

    // short press
    clr();
    run(0, 5);
    run(1, DBL_GAP + 2);
    cnt_chk("s1", 1, 0, 0);

    // long press held well past threshold
    clr();
    run(0, 16);
    run(0, 40);
    run(1, 12);
    cnt_chk("s2", 0, 1, 0);

    // LONG_CYC-1 vs LONG_CYC edge
    clr();
    run(0, 15);
    run(1, 10);
    cnt_chk("s3a", 1, 0, 0);
    clr();
    run(0, 16);
    run(1, 10);
    cnt_chk("s3b", 0, 1, 0);

    // gap DBL_GAP-1 is a double, gap DBL_GAP is two shorts
    clr();
    run(0, 4);
    run(1, 7);
    run(0, 4);
    run(1, 10);
    cnt_chk("s4a", 0, 0, 1);
    clr();
    run(0, 4);
    run(1, 8);
    run(0, 4);
    run(1, 10);
    cnt_chk("s4b", 2, 0, 0);

    // long second press is still a double
    clr();
    run(0, 4);
    run(1, 3);
    run(0, 30);
    chk("s5_pressed", {31'd0, pressed}, 32'd1);
    run(1, 10);
    cnt_chk("s5", 0, 0, 1);

    // key held through reset release is ignored
    clr();
    do_reset(1'b0);
    run(0, 10);
    cnt_chk("s6a", 0, 0, 0);
    run(1, 3);
    run(0, 5);
    run(1, 10);
    cnt_chk("s6b", 1, 0, 0);

    // reset in the middle of a press discards it
    clr();
    run(0, 3);
    do_reset(1'b0);
    run(0, 5);
    run(1, 10);
    cnt_chk("s6c", 0, 0, 0);

    // random run lengths with occasional reset
    lvl = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        do_reset(lvl);
      end
      run(lvl, int'($urandom_range(1, 20)));
      lvl = ~lvl;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
